// File: rtl/dmem_ctrl.sv
`default_nettype none
// dmem_ctrl: two-requester front end for a 32-bit word memory with sub-word load extension and RMW stores.
// Define DMEM_CTRL_RR_EN for round-robin arbitration; fixed priority (FIXED_PRIO) otherwise.
module dmem_ctrl #(
  parameter int ADDR_W     = 11,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              r0_req_i,
  input  logic              r0_we_i,
  input  logic [1:0]        r0_size_i,
  input  logic              r0_unsigned_i,
  input  logic [ADDR_W-1:0] r0_addr_i,
  input  logic [31:0]       r0_wdata_i,
  output logic              r0_gnt_o,
  output logic              r0_rvalid_o,
  output logic [31:0]       r0_rdata_o,
  output logic              r0_err_o,
  input  logic              r1_req_i,
  input  logic              r1_we_i,
  input  logic [1:0]        r1_size_i,
  input  logic              r1_unsigned_i,
  input  logic [ADDR_W-1:0] r1_addr_i,
  input  logic [31:0]       r1_wdata_i,
  output logic              r1_gnt_o,
  output logic              r1_rvalid_o,
  output logic [31:0]       r1_rdata_o,
  output logic              r1_err_o,
  output logic              mem_st_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_st_data_o,
  input  logic [31:0]       mem_ld_data_i
);

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_RMW_WR = 1'b1} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic [ADDR_W-1:0] rmw_addr_q, rmw_addr_d;
  logic [31:0]       merged_q, merged_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;
`ifdef DMEM_CTRL_RR_EN
  logic              rr_q, rr_d;
`endif

  logic              any_req, win;
  logic              sel_we, sel_uns;
  logic [1:0]        sel_size, off;
  logic [ADDR_W-1:0] sel_addr, word_addr;
  logic [31:0]       sel_wdata, shifted, ld_ext, lane_mask, merged_word;
  logic [4:0]        shamt;
  logic              misaligned, word_store, sub_store;

  // Grants are only possible in IDLE and never while reset is held.
  always_comb begin
    any_req = rst_ni && (state_q == ST_IDLE) && (r0_req_i || r1_req_i);
    if (r0_req_i && r1_req_i) begin
`ifdef DMEM_CTRL_RR_EN
      win = rr_q;
`else
      win = (FIXED_PRIO != 0);
`endif
    end else begin
      win = r1_req_i;
    end
  end

  assign r0_gnt_o = any_req && !win;
  assign r1_gnt_o = any_req && win;

  always_comb begin
    sel_we    = win ? r1_we_i       : r0_we_i;
    sel_uns   = win ? r1_unsigned_i : r0_unsigned_i;
    sel_size  = win ? r1_size_i     : r0_size_i;
    sel_addr  = win ? r1_addr_i     : r0_addr_i;
    sel_wdata = win ? r1_wdata_i    : r0_wdata_i;
    off       = sel_addr[1:0];
    shamt     = {off, 3'b000};
    word_addr = {sel_addr[ADDR_W-1:2], 2'b00};

    misaligned = (sel_size == 2'd3) || (sel_size == 2'd1 && off[0]) ||
                 (sel_size == 2'd2 && off != 2'd0);
    word_store = sel_we && !misaligned && (sel_size == 2'd2);
    sub_store  = sel_we && !misaligned && (sel_size != 2'd2);

    shifted = mem_ld_data_i >> shamt;
    case (sel_size)
      2'd0:    ld_ext = {{24{~sel_uns & shifted[7]}}, shifted[7:0]};
      2'd1:    ld_ext = {{16{~sel_uns & shifted[15]}}, shifted[15:0]};
      default: ld_ext = shifted;
    endcase

    lane_mask   = ((sel_size == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF) << shamt;
    merged_word = (mem_ld_data_i & ~lane_mask) | ((sel_wdata << shamt) & lane_mask);
  end

  always_comb begin
    mem_st_en_o   = 1'b0;
    mem_addr_o    = word_addr;
    mem_st_data_o = sel_wdata;
    if (state_q == ST_RMW_WR) begin
      mem_st_en_o   = 1'b1;
      mem_addr_o    = rmw_addr_q;
      mem_st_data_o = merged_q;
    end else if (any_req && word_store) begin
      mem_st_en_o = 1'b1;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rmw_addr_d = rmw_addr_q;
    merged_d   = merged_q;
    rvalid_d   = 2'b00;
    rdata_d    = 32'h0;
    err_d      = 1'b0;
`ifdef DMEM_CTRL_RR_EN
    rr_d       = rr_q;
`endif
    if (state_q == ST_RMW_WR) begin
      state_d           = ST_IDLE;
      rvalid_d[owner_q] = 1'b1;
    end else if (any_req) begin
`ifdef DMEM_CTRL_RR_EN
      rr_d = ~win;
`endif
      if (misaligned) begin
        rvalid_d[win] = 1'b1;
        err_d         = 1'b1;
      end else if (sub_store) begin
        // Old word is sampled this edge; the merged word is written next cycle.
        state_d    = ST_RMW_WR;
        owner_d    = win;
        rmw_addr_d = word_addr;
        merged_d   = merged_word;
      end else begin
        rvalid_d[win] = 1'b1;
        if (!sel_we) rdata_d = ld_ext;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      owner_q    <= 1'b0;
      rmw_addr_q <= '0;
      merged_q   <= 32'h0;
      rvalid_q   <= 2'b00;
      rdata_q    <= 32'h0;
      err_q      <= 1'b0;
`ifdef DMEM_CTRL_RR_EN
      rr_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      rmw_addr_q <= rmw_addr_d;
      merged_q   <= merged_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
`ifdef DMEM_CTRL_RR_EN
      rr_q       <= rr_d;
`endif
    end
  end

  assign r0_rvalid_o = rvalid_q[0];
  assign r1_rvalid_o = rvalid_q[1];
  assign r0_rdata_o  = rvalid_q[0] ? rdata_q : 32'h0;
  assign r1_rdata_o  = rvalid_q[1] ? rdata_q : 32'h0;
  assign r0_err_o    = rvalid_q[0] & err_q;
  assign r1_err_o    = rvalid_q[1] & err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_ctrl.sv
`default_nettype none
// tb_dmem_ctrl: randomized scoreboard bench for dmem_ctrl against a word-array reference model.
module tb_dmem_ctrl;
  localparam int ADDR_W     = 11;
  localparam int FIXED_PRIO = 0;
  localparam int DEPTH      = 1 << (ADDR_W - 2);
`ifdef DMEM_CTRL_RR_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  logic [1:0]             req = 2'b00, we = 2'b00, uns = 2'b00;
  logic [1:0][1:0]        size = '0;
  logic [1:0][ADDR_W-1:0] addr = '0;
  logic [1:0][31:0]       wdata = '0;
  logic [1:0]             gnt, rvalid, err;
  logic [1:0][31:0]       rdata;
  logic                   mem_st_en;
  logic [ADDR_W-1:0]      mem_addr;
  logic [31:0]            mem_st_data, mem_ld;

  logic [31:0] mem     [DEPTH];
  logic [31:0] ref_mem [DEPTH];

  exp_t q0[$], q1[$];
  int   cyc = 0, checks = 0, errors = 0;
  int   st_cnt = 0, rv_cnt = 0;
  int   gcount[2];
  logic [31:0] last_st = 32'h0;
  logic [1:0][31:0] last_rdata = '0;
  logic [1:0] done = 2'b00;
  logic busy = 1'b0, prefer = 1'b0;

  dmem_ctrl #(.ADDR_W(ADDR_W), .FIXED_PRIO(FIXED_PRIO)) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .r0_req_i(req[0]), .r0_we_i(we[0]), .r0_size_i(size[0]), .r0_unsigned_i(uns[0]),
    .r0_addr_i(addr[0]), .r0_wdata_i(wdata[0]), .r0_gnt_o(gnt[0]), .r0_rvalid_o(rvalid[0]),
    .r0_rdata_o(rdata[0]), .r0_err_o(err[0]),
    .r1_req_i(req[1]), .r1_we_i(we[1]), .r1_size_i(size[1]), .r1_unsigned_i(uns[1]),
    .r1_addr_i(addr[1]), .r1_wdata_i(wdata[1]), .r1_gnt_o(gnt[1]), .r1_rvalid_o(rvalid[1]),
    .r1_rdata_o(rdata[1]), .r1_err_o(err[1]),
    .mem_st_en_o(mem_st_en), .mem_addr_o(mem_addr), .mem_st_data_o(mem_st_data),
    .mem_ld_data_i(mem_ld)
  );

  always #5 clk = ~clk;

  assign mem_ld = mem_st_en ? 32'h0 : mem[mem_addr[ADDR_W-1:2]];
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_st_en) mem[mem_addr[ADDR_W-1:2]] <= mem_st_data;
  end

  function automatic logic is_mis(input logic [1:0] sz, input logic [1:0] off);
    return (sz == 2'd3) || (sz == 2'd1 && off[0]) || (sz == 2'd2 && off != 2'd0);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic u, input logic [1:0] off);
    int sh = 8 * int'(off);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (w >> sh) & 32'hFF;
      if (!u && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (w >> sh) & 32'hFFFF;
      if (!u && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] d,
                                            input logic [1:0] sz, input logic [1:0] off);
    int sh = 8 * int'(off);
    logic [31:0] m;
    m = (sz == 2'd0) ? 32'hFF : (sz == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    m = m << sh;
    return (w & ~m) | ((d << sh) & m);
  endfunction

  // Monitor + arbitration model + scoreboard push, all sampled mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    logic [1:0] exp_g;
    int w, idx;
    logic [1:0] off;
    logic mis;
    if (!rst_ni) begin
      q0.delete();
      q1.delete();
      busy   = 1'b0;
      prefer = 1'b0;
    end else begin
      if (mem_st_en) begin
        st_cnt++;
        last_st = mem_st_data;
      end
      for (int n = 0; n < 2; n++) begin
        if (rvalid[n]) begin
          rv_cnt++;
          checks++;
          if ((n == 0 ? q0.size() : q1.size()) == 0) begin
            errors++;
            $display("FAIL resp%0d_unexpected: got rvalid rdata=%h err=%b at cycle %0d, required no response",
                     n, rdata[n], err[n], cyc);
          end else begin
            e = (n == 0) ? q0.pop_front() : q1.pop_front();
            last_rdata[n] = rdata[n];
            if (rdata[n] !== e.rdata || err[n] !== e.err || cyc != e.cyc) begin
              errors++;
              $display("FAIL resp%0d: got rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                       n, rdata[n], err[n], cyc, e.rdata, e.err, e.cyc);
            end
          end
        end
      end
      exp_g = 2'b00;
      w = 0;
      if (!busy && req != 2'b00) begin
        if (req == 2'b11) w = RR_EN ? int'(prefer) : FIXED_PRIO;
        else              w = req[1] ? 1 : 0;
        exp_g[w] = 1'b1;
      end
      if (busy || req != 2'b00) begin
        checks++;
        if (gnt !== exp_g) begin
          errors++;
          $display("FAIL gnt: got %b, required %b (req=%b cycle %0d)", gnt, exp_g, req, cyc);
        end
      end
      busy = 1'b0;
      if (exp_g != 2'b00) begin
        off = addr[w][1:0];
        idx = int'(addr[w][ADDR_W-1:2]);
        mis = is_mis(size[w], off);
        gcount[w]++;
        done[w] = 1'b1;
        prefer  = (w == 0);
        e.cyc   = cyc + 1;
        e.err   = mis;
        e.rdata = 32'h0;
        if (!mis) begin
          if (!we[w]) begin
            e.rdata = ref_load(ref_mem[idx], size[w], uns[w], off);
          end else begin
            ref_mem[idx] = ref_store(ref_mem[idx], wdata[w], size[w], off);
            if (size[w] != 2'd2) begin
              e.cyc = cyc + 2;
              busy  = 1'b1;
            end
          end
        end
        if (w == 0) q0.push_back(e);
        else        q1.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic set_req(input int n, input logic w_e, input logic [1:0] sz, input logic u,
                         input logic [ADDR_W-1:0] a, input logic [31:0] d);
    req[n] = 1'b1; we[n] = w_e; size[n] = sz; uns[n] = u; addr[n] = a; wdata[n] = d;
  endtask

  task automatic wait_gnt(input int n);
    int k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while (!done[n] && k < 50);
    if (!done[n]) begin
      checks++;
      errors++;
      $display("FAIL gnt%0d_timeout: got no grant in 50 cycles, required a grant", n);
    end
  endtask

  task automatic issue(input int n, input logic w_e, input logic [1:0] sz, input logic u,
                       input logic [ADDR_W-1:0] a, input logic [31:0] d);
    set_req(n, w_e, sz, u, a, d);
    wait_gnt(n);
    tick();
    req[n]  = 1'b0;
    done[n] = 1'b0;
  endtask

  task automatic drain();
    repeat (4) tick();
  endtask

  task automatic rand_req(input int n);
    set_req(n, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ADDR_W'($urandom_range(0, 63)), $urandom());
  endtask

  initial begin
    logic [31:0] saved;
    gcount[0] = 0;
    gcount[1] = 0;
    for (int i = 0; i < DEPTH; i++) begin
      mem[i]     = $urandom();
      ref_mem[i] = mem[i];
    end
    mem[32'h010 >> 2] = 32'hDEAD_BEEF; ref_mem[32'h010 >> 2] = 32'hDEAD_BEEF;
    mem[32'h020 >> 2] = 32'h80FF_7F01; ref_mem[32'h020 >> 2] = 32'h80FF_7F01;
    mem[32'h040 >> 2] = 32'h1122_3344; ref_mem[32'h040 >> 2] = 32'h1122_3344;

    // Reset state, with a word store pending to show nothing leaks through.
    set_req(0, 1'b1, 2'd2, 1'b0, 11'h010, 32'h1234_5678);
    repeat (2) tick();
    check("reset_outputs", {30'h0, gnt | rvalid | err}, 32'h0);
    check("reset_st_en", {31'h0, mem_st_en}, 32'h0);
    check("reset_rdata", rdata[0] | rdata[1], 32'h0);
    req = 2'b00;
    tick();
    rst_ni = 1'b1;
    tick();

    issue(0, 1'b0, 2'd2, 1'b0, 11'h010, 32'h0); drain(); check("lw_010", last_rdata[0], 32'hDEAD_BEEF);
    issue(0, 1'b0, 2'd0, 1'b0, 11'h022, 32'h0); drain(); check("lb_022", last_rdata[0], 32'hFFFF_FFFF);
    issue(0, 1'b0, 2'd0, 1'b1, 11'h022, 32'h0); drain(); check("lbu_022", last_rdata[0], 32'h0000_00FF);
    issue(1, 1'b0, 2'd1, 1'b0, 11'h020, 32'h0); drain(); check("lh_020", last_rdata[1], 32'h0000_7F01);
    issue(1, 1'b0, 2'd1, 1'b0, 11'h022, 32'h0); drain(); check("lh_022", last_rdata[1], 32'hFFFF_80FF);

    st_cnt = 0;
    issue(1, 1'b1, 2'd0, 1'b0, 11'h041, 32'h0000_00AA); drain();
    check("sb_st_cycles", st_cnt, 32'd1);
    check("sb_st_data", last_st, 32'h1122_AA44);
    check("sb_mem", mem[32'h040 >> 2], 32'h1122_AA44);
    issue(0, 1'b0, 2'd2, 1'b0, 11'h040, 32'h0); drain(); check("lw_after_sb", last_rdata[0], 32'h1122_AA44);

    st_cnt = 0;
    issue(0, 1'b1, 2'd2, 1'b0, 11'h042, 32'h5555_5555); drain();
    check("mis_st_cycles", st_cnt, 32'd0);
    check("mis_mem", mem[32'h040 >> 2], 32'h1122_AA44);

    // Contention: both requesters present loads on four consecutive cycles.
    gcount[0] = 0;
    gcount[1] = 0;
    for (int n = 0; n < 2; n++) set_req(n, 1'b0, 2'd2, 1'b0, ADDR_W'($urandom_range(0, 15) * 4), 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      tick();
      for (int n = 0; n < 2; n++) begin
        if (done[n]) begin
          done[n] = 1'b0;
          set_req(n, 1'b0, 2'd2, 1'b0, ADDR_W'($urandom_range(0, 15) * 4), 32'h0);
        end
      end
    end
    req  = 2'b00;
    done = 2'b00;
    drain();
    check("contention_r0", gcount[0], RR_EN ? 32'd2 : ((FIXED_PRIO == 0) ? 32'd4 : 32'd0));
    check("contention_r1", gcount[1], RR_EN ? 32'd2 : ((FIXED_PRIO == 0) ? 32'd0 : 32'd4));

    // Randomized mixed traffic over a small window to force address reuse.
    for (int c = 0; c < 3000; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (!req[n] || done[n]) begin
          done[n] = 1'b0;
          if ($urandom_range(0, 3) != 0) rand_req(n);
          else                            req[n] = 1'b0;
        end
      end
      tick();
    end
    req  = 2'b00;
    done = 2'b00;
    drain();

    // Reset landing in the RMW write cycle must suppress the write and the response.
    mem[32'h080 >> 2] = 32'hCAFE_F00D;
    ref_mem[32'h080 >> 2] = 32'hCAFE_F00D;
    saved = 32'hCAFE_F00D;
    set_req(0, 1'b1, 2'd0, 1'b0, 11'h081, 32'h0000_0055);
    wait_gnt(0);
    tick();
    req  = 2'b00;
    done = 2'b00;
    check("rmw_wr_st_en", {31'h0, mem_st_en}, 32'd1);
    rst_ni = 1'b0;
    #1;
    check("rst_st_en_drop", {31'h0, mem_st_en}, 32'd0);
    check("rst_rvalid", {30'h0, rvalid}, 32'd0);
    ref_mem[32'h080 >> 2] = saved;
    repeat (2) tick();
    rst_ni = 1'b1;
    rv_cnt = 0;
    repeat (5) tick();
    check("rst_no_rvalid", rv_cnt, 32'd0);
    check("rst_mem", mem[32'h080 >> 2], saved);

    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL pending_resp: got %0d/%0d outstanding, required 0/0", q0.size(), q1.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
